cache_ctrl_nway: RTL
====================

# cache_ctrl_nway

Parametrised next-generation cache controller FSM for the AXI-4 based cache core. It sequences tag/data/dirty/LRU array updates for an N-way set-associative cache with multi-beat line transfers, and has selectable write-back or write-through policy and selectable write-allocate. It sits between the CPU request port and the AXI-4 master adapter, alongside the tag, data, dirty and LRU arrays.

## Interface
- WAYS, 4: associativity, power of 2, ≥2; WAY_W = $clog2(WAYS)
- BEATS, 4: words per line, power of 2, ≥2; BEAT_W = $clog2(BEATS)
- WRITE_BACK, 1: 1 = write-back, 0 = write-through
- WRITE_ALLOC, 1: 1 = allocate on write miss, 0 = write-around
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in/out  1  CPU request handshake
- req_rw  in  1  1 = write; sampled on accept
- resp_valid  out  1  one-cycle completion pulse (read data valid or write done)
- resp_hit  out  1  qualifies resp_valid: 1 if the original lookup hit
- way_match / way_valid / way_dirty  in  WAYS  per-way lookup results for the captured index
- lru_victim  in  WAY_W  LRU-selected way
- arr_way  out  WAY_W  way addressed by all array strobes
- arr_beat  out  BEAT_W  word within line
- data_we_cpu / data_we_fill  out  1  data write from CPU word / memory beat
- tag_we, valid_set, dirty_set, dirty_clr, lru_touch  out  1  array strobes
- mem_req_valid / mem_req_ready  out/in  1  memory command handshake
- mem_req_rw  out  1  1 = write
- mem_req_burst  out  1  1 = BEATS-beat line, 0 = single word
- mem_req_victim  out  1  1 = address from victim tag (write-back), 0 = CPU address
- mem_wvalid / mem_wready  out/in  1  write beat handshake
- mem_wlast  out  1  final write beat
- mem_rvalid  in  1  read beat valid; the controller always accepts

## Operation
- States: IDLE, LOOKUP, WB_REQ, WB_DATA, LD_REQ, LD_DATA, WT_REQ, WT_DATA.
- IDLE: req_ready=1. On req_valid, capture req_rw and go to LOOKUP.
- LOOKUP: hit = |way_match. arr_way is the one-hot-encoded match index. way_match is guaranteed one-hot or zero.
  - Read hit: resp_valid=1, resp_hit=1, lru_touch. Go to IDLE.
  - Write hit: data_we_cpu and lru_touch. If WRITE_BACK: dirty_set, resp_valid=1, go to IDLE. Otherwise go to WT_REQ.
  - Write miss with WRITE_ALLOC=0: go to WT_REQ with no array strobes.
  - Other misses: the victim is the lowest-index way with way_valid=0, or lru_victim if all ways are valid. The victim is registered.
    - If WRITE_BACK and the victim is valid and dirty: go to WB_REQ.
    - Otherwise: go to LD_REQ.
- WB_REQ: mem_req_valid, rw=1, burst=1, victim=1. Go to WB_DATA on mem_req_ready.
- WB_DATA: mem_wvalid. arr_beat comes from the beat counter, which advances on mem_wready. mem_wlast is set when beat = BEATS-1. On the last accepted beat: dirty_clr, go to LD_REQ.
- LD_REQ: mem_req_valid, rw=0, burst=1, victim=0. Go to LD_DATA on mem_req_ready.
- LD_DATA: each mem_rvalid gives data_we_fill at arr_beat, then the counter advances. The last beat also gives tag_we and valid_set, then go to LOOKUP (replay). The replay hits, so the response is taken from the hit path with resp_hit forced to 0 (a sticky miss flag, cleared in IDLE).
- WT_REQ / WT_DATA: single-word write (burst=0, victim=0). The one beat has mem_wlast=1. On mem_wready: resp_valid=1, go to IDLE.
- Write-through never sets dirty_set. When WRITE_BACK=0, WB_* states are unreachable.

## Timing
- Reset (async, rst_n low): state=IDLE, beat counter=0, victim reg=0, miss flag=0. All outputs are 0, including req_ready. A ready-enable register set on the first clk edge after deassert gates req_ready.
- All outputs are Moore, decoded from state and registered context, except the LOOKUP strobes and mem_* handshake-dependent strobes, which also depend on same-cycle inputs.
- Read hit latency: accept edge → LOOKUP → resp_valid in the first LOOKUP cycle (1 cycle after accept).
- Clean miss minimum latency: LOOKUP + LD_REQ(1) + BEATS + replay LOOKUP = BEATS+3 cycles after accept. Dirty miss adds 1+BEATS.
- The beat counter wraps from BEATS-1 to 0 on the last beat and is 0 on entry to every data state.
- mem_req_valid holds with stable fields until ready. mem_wvalid holds until mem_wready.
- The CPU request is not re-sampled until the next IDLE. Back-to-back requests therefore have a one-cycle IDLE gap.

## Structure
- cache_pkg:
  - cache_state_e enum
  - WAY_W/BEAT_W helper function
  - mem command fields struct (rw, burst, victim)
- Sub-module cache_beat_ctr: parametrised BEATS counter with inc, clr and last outputs. It is used for both the WB and LD bursts.

## Test plan
- Read hit, WAYS=4, way_match=4'b0100 → resp_valid, resp_hit=1, arr_way=2, lru_touch in the cycle after accept; back in IDLE the next cycle.
- Read miss, way_valid=4'b0111 → victim way 3 with lru_victim ignored. There are 4 data_we_fill pulses at beats 0..3, then tag_we+valid_set, then resp_valid with resp_hit=0.
- Write miss, all ways valid, lru_victim=1, way_dirty[1]=1, WRITE_BACK=1 → WB burst of 4 beats with mem_wlast on beat 3, dirty_clr, load burst, replay, then dirty_set with resp_valid.
- WRITE_BACK=0: write hit → data_we_cpu, single-beat write (burst=0, wlast=1), resp_valid after mem_wready; dirty_set never asserts.
- WRITE_ALLOC=0: write miss → no tag_we or data strobes, single-word write, resp_valid with resp_hit=0.
- Assert rst_n low mid-LD_DATA at beat 2 → immediate IDLE with all outputs 0. req_ready returns 1 the cycle after the first post-deassert edge, and a new read completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the N-way cache controller: FSM state encoding, memory
// command fields and the index-width helper used to size way/beat ports.
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOOKUP  = 3'd1,
      ST_WB_REQ  = 3'd2,
      ST_WB_DATA = 3'd3,
      ST_LD_REQ  = 3'd4,
      ST_LD_DATA = 3'd5,
      ST_WT_REQ  = 3'd6,
      ST_WT_DATA = 3'd7
   } cache_state_e;

   typedef struct packed {
      logic rw;
      logic burst;
      logic victim;
   } mem_cmd_t;

   // Index width for a power-of-two count; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_beat_ctr.sv
// Word-within-line counter shared by the write-back and line-fill bursts.
// Wraps to zero on the last beat so every burst starts at beat 0.
module cache_beat_ctr
   import cache_pkg::*;
#(
   parameter  int BEATS  = 4,
   localparam int BEAT_W = idx_width(BEATS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              clr,
   output logic [BEAT_W-1:0] beat,
   output logic              last
);

   logic [BEAT_W-1:0] beat_r;

   assign beat = beat_r;
   assign last = (beat_r == BEAT_W'(BEATS - 1));

   // Beat register: clear has priority, increment wraps after the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_r <= '0;
      end else if (clr) begin
         beat_r <= '0;
      end else if (inc) begin
         beat_r <= last ? '0 : beat_r + 1'b1;
      end else begin
         beat_r <= beat_r;
      end
   end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache controller FSM: sequences tag/data/dirty/LRU
// strobes and the memory command/beat handshakes for hits, fills and writes.
module cache_ctrl_nway
   import cache_pkg::*;
#(
   parameter  int WAYS        = 4,
   parameter  int BEATS       = 4,
   parameter  bit WRITE_BACK  = 1'b1,
   parameter  bit WRITE_ALLOC = 1'b1,
   localparam int WAY_W       = idx_width(WAYS),
   localparam int BEAT_W      = idx_width(BEATS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   output logic              resp_valid,
   output logic              resp_hit,
   input  logic [WAYS-1:0]   way_match,
   input  logic [WAYS-1:0]   way_valid,
   input  logic [WAYS-1:0]   way_dirty,
   input  logic [WAY_W-1:0]  lru_victim,
   output logic [WAY_W-1:0]  arr_way,
   output logic [BEAT_W-1:0] arr_beat,
   output logic              data_we_cpu,
   output logic              data_we_fill,
   output logic              tag_we,
   output logic              valid_set,
   output logic              dirty_set,
   output logic              dirty_clr,
   output logic              lru_touch,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic              mem_req_burst,
   output logic              mem_req_victim,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   output logic              mem_wlast,
   input  logic              mem_rvalid
);

   cache_state_e      state_r;
   cache_state_e      state_s;
   logic              rdy_en_r;
   logic              rw_r;
   logic              miss_r;
   logic [WAY_W-1:0]  way_r;
   logic              hit_s;
   logic [WAY_W-1:0]  match_idx_s;
   logic [WAY_W-1:0]  victim_s;
   logic              victim_dirty_s;
   logic [BEAT_W-1:0] beat_s;
   logic              last_s;
   logic              inc_s;
   logic              clr_s;
   mem_cmd_t          cmd_s;

   cache_beat_ctr #(.BEATS(BEATS)) u_beat_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_s),
      .clr   (clr_s),
      .beat  (beat_s),
      .last  (last_s)
   );

   assign hit_s          = |way_match;
   assign clr_s          = (state_r == ST_IDLE);
   assign victim_dirty_s = way_valid[victim_s] & way_dirty[victim_s];
   assign mem_req_rw     = cmd_s.rw;
   assign mem_req_burst  = cmd_s.burst;
   assign mem_req_victim = cmd_s.victim;

   // Encode the one-hot match and pick the lowest invalid way, else the LRU way.
   always_comb begin
      match_idx_s = '0;
      victim_s    = lru_victim;
      for (int i = 0; i < WAYS; i++) begin
         match_idx_s = match_idx_s | (way_match[i] ? WAY_W'(i) : '0);
      end
      for (int i = WAYS - 1; i >= 0; i--) begin
         victim_s = way_valid[i] ? victim_s : WAY_W'(i);
      end
   end

   // State register plus the post-reset enable that gates req_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         rdy_en_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         rdy_en_r <= 1'b1;
      end
   end

   // Request context: captured direction, sticky miss flag and selected way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_r   <= 1'b0;
         miss_r <= 1'b0;
         way_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               miss_r <= 1'b0;
               if (req_valid && rdy_en_r) begin
                  rw_r <= req_rw;
               end else begin
                  rw_r <= rw_r;
               end
            end
            ST_LOOKUP: begin
               // The replay after a fill hits, so the flag must survive it.
               miss_r <= miss_r | ~hit_s;
               way_r  <= hit_s ? match_idx_s : victim_s;
            end
            default: begin
               miss_r <= miss_r;
            end
         endcase
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_s      = state_r;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_hit     = 1'b0;
      arr_way      = way_r;
      arr_beat     = '0;
      data_we_cpu  = 1'b0;
      data_we_fill = 1'b0;
      tag_we       = 1'b0;
      valid_set    = 1'b0;
      dirty_set    = 1'b0;
      dirty_clr    = 1'b0;
      lru_touch    = 1'b0;
      mem_req_valid = 1'b0;
      mem_wvalid   = 1'b0;
      mem_wlast    = 1'b0;
      inc_s        = 1'b0;
      cmd_s        = '0;
      case (state_r)
         ST_IDLE: begin
            req_ready = rdy_en_r;
            if (req_valid && rdy_en_r) begin
               state_s = ST_LOOKUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            arr_way = match_idx_s;
            if (hit_s) begin
               lru_touch = 1'b1;
               if (!rw_r) begin
                  resp_valid = 1'b1;
                  resp_hit   = ~miss_r;
                  state_s    = ST_IDLE;
               end else if (WRITE_BACK) begin
                  data_we_cpu = 1'b1;
                  dirty_set   = 1'b1;
                  resp_valid  = 1'b1;
                  resp_hit    = ~miss_r;
                  state_s     = ST_IDLE;
               end else begin
                  data_we_cpu = 1'b1;
                  state_s     = ST_WT_REQ;
               end
            end else if (rw_r && !WRITE_ALLOC) begin
               state_s = ST_WT_REQ;
            end else if (WRITE_BACK && victim_dirty_s) begin
               state_s = ST_WB_REQ;
            end else begin
               state_s = ST_LD_REQ;
            end
         end
         ST_WB_REQ: begin
            mem_req_valid = 1'b1;
            cmd_s         = '{rw: 1'b1, burst: 1'b1, victim: 1'b1};
            state_s       = mem_req_ready ? ST_WB_DATA : ST_WB_REQ;
         end
         ST_WB_DATA: begin
            mem_wvalid = 1'b1;
            arr_beat   = beat_s;
            mem_wlast  = last_s;
            inc_s      = mem_wready;
            if (mem_wready && last_s) begin
               dirty_clr = 1'b1;
               state_s   = ST_LD_REQ;
            end else begin
               state_s   = ST_WB_DATA;
            end
         end
         ST_LD_REQ: begin
            mem_req_valid = 1'b1;
            cmd_s         = '{rw: 1'b0, burst: 1'b1, victim: 1'b0};
            state_s       = mem_req_ready ? ST_LD_DATA : ST_LD_REQ;
         end
         ST_LD_DATA: begin
            arr_beat     = beat_s;
            data_we_fill = mem_rvalid;
            inc_s        = mem_rvalid;
            if (mem_rvalid && last_s) begin
               tag_we    = 1'b1;
               valid_set = 1'b1;
               state_s   = ST_LOOKUP;
            end else begin
               state_s   = ST_LD_DATA;
            end
         end
         ST_WT_REQ: begin
            mem_req_valid = 1'b1;
            cmd_s         = '{rw: 1'b1, burst: 1'b0, victim: 1'b0};
            state_s       = mem_req_ready ? ST_WT_DATA : ST_WT_REQ;
         end
         ST_WT_DATA: begin
            mem_wvalid = 1'b1;
            mem_wlast  = 1'b1;
            if (mem_wready) begin
               resp_valid = 1'b1;
               resp_hit   = ~miss_r;
               state_s    = ST_IDLE;
            end else begin
               state_s    = ST_WT_DATA;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

endmodule
